align_reg_out: RTL and testbench

Output de-skew stage for the convolution systolic array. Each PE column emits its partial sums diagonally: within a beat, lane k of every group arrives k cycles after lane 0. This block delays each lane by a complementary amount so that all lanes of a beat leave together as one aligned word, with matching valid and last. It sits between the PE array outputs and the post-processing (bias/requant) stage, mirroring the input skew stage in front of the array.

---
 rtl/align_reg_out.sv | 106 ++++++++++
 tb/tb_align_reg_out.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/align_reg_out.sv
// Output de-skew for the systolic array: lane k is delayed LANES-k cycles so
// every lane of a beat leaves together, with valid/last carried alongside.
module align_reg_out #(
  parameter int unsigned LANES       = 9,
  parameter int unsigned GROUPS      = 18,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned GROUP_WIDTH = LANES * DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = $clog2(LANES + 1)
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [GROUP_WIDTH*GROUPS-1:0] data_in,
  input  logic                          valid_in,
  input  logic                          last_in,
  output logic [GROUP_WIDTH*GROUPS-1:0] data_out,
  output logic                          valid_out,
  output logic                          last_out,
  output logic [CNT_WIDTH-1:0]          inflight,
  output logic                          busy
);

  localparam int unsigned LANE_BUS = GROUPS * DATA_WIDTH;

  logic [LANE_BUS-1:0]  lane_out [LANES];
  logic [LANES-1:0]     valid_q, valid_d;
  logic [LANES-1:0]     last_q,  last_d;
  logic [CNT_WIDTH-1:0] inflight_q, inflight_d;

  // Each lane gathers its slice from every group so one chain serves all groups.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int unsigned DEPTH = LANES - k;

    logic [LANE_BUS-1:0] lane_in;
    logic [LANE_BUS-1:0] chain_q [DEPTH];

    always_comb begin
      lane_in = '0;
      for (int unsigned g = 0; g < GROUPS; g++) begin
        lane_in[g*DATA_WIDTH +: DATA_WIDTH] = data_in[g*GROUP_WIDTH + k*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        for (int unsigned s = 0; s < DEPTH; s++) begin
          chain_q[s] <= '0;
        end
      end else begin
        chain_q[0] <= lane_in;
        for (int unsigned s = 1; s < DEPTH; s++) begin
          chain_q[s] <= chain_q[s-1];
        end
      end
    end

    assign lane_out[k] = chain_q[DEPTH-1];
  end

  always_comb begin
    valid_d    = valid_q;
    last_d     = last_q;
    valid_d[0] = valid_in;
    last_d[0]  = last_in & valid_in;
    for (int unsigned i = 1; i < LANES; i++) begin
      valid_d[i] = valid_q[i-1];
      last_d[i]  = last_q[i-1];
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    if (valid_in && !valid_out && inflight_q != CNT_WIDTH'(LANES)) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!valid_in && valid_out && inflight_q != '0) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q    <= '0;
      last_q     <= '0;
      inflight_q <= '0;
    end else begin
      valid_q    <= valid_d;
      last_q     <= last_d;
      inflight_q <= inflight_d;
    end
  end

  assign valid_out = valid_q[LANES-1];
  assign last_out  = last_q[LANES-1];
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != '0);

  always_comb begin
    data_out = '0;
    for (int unsigned g = 0; g < GROUPS; g++) begin
      for (int unsigned k = 0; k < LANES; k++) begin
        data_out[g*GROUP_WIDTH + k*DATA_WIDTH +: DATA_WIDTH] =
          valid_out ? lane_out[k][g*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
  end

endmodule

// File: tb/tb_align_reg_out.sv
// Scoreboard bench for align_reg_out: skewed beats are driven, expected aligned
// words are queued at issue time and checked by an independent monitor.
module tb_align_reg_out;

  localparam int LANES  = 9;
  localparam int GROUPS = 18;
  localparam int DW     = 32;
  localparam int GW     = LANES * DW;
  localparam int W      = GW * GROUPS;
  localparam int CW     = $clog2(LANES + 1);
  localparam int TBL    = 1024;

  logic          clk = 1'b0;
  logic          rstn;
  logic [W-1:0]  data_in;
  logic          valid_in;
  logic          last_in;
  logic [W-1:0]  data_out;
  logic          valid_out;
  logic          last_out;
  logic [CW-1:0] inflight;
  logic          busy;

  align_reg_out #(
    .LANES      (LANES),
    .GROUPS     (GROUPS),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .last_in   (last_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .last_out  (last_out),
    .inflight  (inflight),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int          edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Beat started at edge e: id (or -1 for none) and whether it is the isolation pattern.
  int start_id  [TBL];
  bit start_iso [TBL];

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic [DW-1:0] lane_val(int id, bit iso, int g, int k);
    if (iso) return (g == GROUPS - 1) ? '1 : '0;
    return DW'((id << 16) | (g << 8) | k);
  endfunction

  function automatic logic [W-1:0] beat_word(int id, bit iso);
    logic [W-1:0] w;
    w = '0;
    for (int g = 0; g < GROUPS; g++)
      for (int k = 0; k < LANES; k++)
        w[g*GW + k*DW +: DW] = lane_val(id, iso, g, k);
    return w;
  endfunction

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic check_word(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < GROUPS * LANES; i++) begin
        if (act[i*DW +: DW] !== exp[i*DW +: DW]) begin
          $display("FAIL %s: group %0d lane %0d got %h want %h (edge %0d)",
                   name, i / LANES, i % LANES, act[i*DW +: DW], exp[i*DW +: DW], edge_cnt);
          break;
        end
      end
    end
  endtask

  // Drive the inputs sampled at the next edge; lanes not owned by a beat carry garbage.
  task automatic step(bit v, bit l, int id, bit iso);
    int e;
    e = edge_cnt;
    if (e >= TBL) begin
      $display("FAIL table_overflow: got %0d want <%0d", e, TBL);
      $fatal(1);
    end
    valid_in = v;
    last_in  = l;
    if (v) begin
      start_id[e]  = id;
      start_iso[e] = iso;
      sb.push_back('{beat_word(id, iso), l & v, e + LANES});
    end
    for (int g = 0; g < GROUPS; g++)
      for (int k = 0; k < LANES; k++)
        if (e >= k && start_id[e-k] >= 0)
          data_in[g*GW + k*DW +: DW] = lane_val(start_id[e-k], start_iso[e-k], g, k);
        else
          data_in[g*GW + k*DW +: DW] = $urandom;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset(int cyc);
    rstn     = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    sb.delete();
    for (int i = 0; i < TBL; i++) start_id[i] = -1;
    #1;
    check_val("rst_valid_out", valid_out, 0);
    check_val("rst_last_out", last_out, 0);
    check_val("rst_inflight", inflight, 0);
    check_val("rst_busy", busy, 0);
    check_word("rst_data_out", data_out, '0);
    repeat (cyc) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  // Monitor: pops on valid_out, otherwise requires a quiet output.
  always @(negedge clk) begin
    exp_t e;
    int   n;
    int   exp_if;
    n = edge_cnt;
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got 1 want 0 (edge %0d)", n);
      end else begin
        e = sb.pop_front();
        check_val("valid_cycle", 64'(n), 64'(e.cyc));
        check_word("beat_data", data_out, e.data);
        check_val("beat_last", last_out, e.last);
      end
    end else begin
      check_word("idle_data", data_out, '0);
      check_val("idle_last", last_out, 0);
      if (sb.size() > 0 && sb[0].cyc <= n) begin
        checks++;
        errors++;
        $display("FAIL missing_valid: got 0 want 1 (edge %0d, due %0d)", n, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
    exp_if = 0;
    for (int i = n - LANES; i < n; i++)
      if (i >= 0 && i < TBL && start_id[i] >= 0) exp_if++;
    check_val("inflight", inflight, 64'(exp_if));
    check_val("busy", busy, 64'(exp_if != 0));
  end

  initial begin
    for (int i = 0; i < TBL; i++) begin
      start_id[i]  = -1;
      start_iso[i] = 1'b0;
    end
    rstn     = 1'b0;
    valid_in = 1'b0;
    last_in  = 1'b0;
    data_in  = '0;
    #1;
    check_val("reset_valid_out", valid_out, 0);
    check_val("reset_last_out", last_out, 0);
    check_val("reset_inflight", inflight, 0);
    check_val("reset_busy", busy, 0);
    check_word("reset_data_out", data_out, '0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Single beat: lane k of group g = g<<8 | k
    step(1'b1, 1'b0, 0, 1'b0);
    idle(12);

    // Back-to-back burst of 20, last on the final beat
    for (int n = 0; n < 20; n++) step(1'b1, n == 19, 100 + n, 1'b0);
    idle(12);

    // Gapped stream 1,0,1,1,0,0,1: four beats accepted, none emitted yet
    step(1'b1, 1'b0, 200, 1'b0);
    step(1'b0, 1'b0, 0,   1'b0);
    step(1'b1, 1'b0, 201, 1'b0);
    step(1'b1, 1'b1, 202, 1'b0);
    step(1'b0, 1'b0, 0,   1'b0);
    step(1'b0, 1'b0, 0,   1'b0);
    step(1'b1, 1'b0, 203, 1'b0);
    check_val("gap_peak_inflight", inflight, 4);
    check_val("gap_peak_busy", busy, 1);
    idle(12);
    check_val("gap_drained_inflight", inflight, 0);
    check_val("gap_drained_busy", busy, 0);

    // last_in pulse with no valid must be ignored
    step(1'b0, 1'b1, 0, 1'b0);
    check_val("lastonly_inflight", inflight, 0);
    idle(12);

    // Group isolation: group 17 all ones, others zero
    step(1'b1, 1'b0, 0, 1'b1);
    idle(12);

    // Mid-flight reset: 5 beats, one idle, reset for 2 cycles, then a fresh beat
    for (int n = 0; n < 5; n++) step(1'b1, n == 4, 300 + n, 1'b0);
    step(1'b0, 1'b0, 0, 1'b0);
    do_reset(2);
    idle(3);
    step(1'b1, 1'b1, 400, 1'b0);
    idle(12);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check_val("scoreboard_empty", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
